pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, the width of the pulse-count fields.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, the width of the half-period field.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a single-cycle request to begin a burst.
REQ-006 SHALL have port stop, input, 1, a synchronous abort of the current burst.
REQ-007 SHALL have port half_period, input, DIV_WIDTH, the high and low phase length in clk cycles.
REQ-008 SHALL have port num_pulses, input, CNT_WIDTH, the number of full periods to emit; 0 means free-run.
REQ-009 SHALL have port pulse, output, 1, the registered square-wave output.
REQ-010 SHALL have port busy, output, 1, high while a burst is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle strobe marking normal burst completion.
REQ-012 SHALL have port pulse_cnt, output, CNT_WIDTH, the number of completed periods in the current or last burst.

Function
REQ-013 SHALL implement the states IDLE, HIGH, LOW and DONE.
REQ-014 SHALL, in IDLE with start=1 and stop=0, latch half_period and num_pulses, clear pulse_cnt and enter HIGH.
REQ-015 SHALL treat a latched half_period of 0 as 1.
REQ-016 SHALL drive pulse=1 in HIGH and pulse=0 in all other states, so pulse rises in the cycle after start is sampled.
REQ-017 SHALL stay in HIGH for exactly H cycles (H = effective half_period), then move to LOW.
REQ-018 SHALL stay in LOW for exactly H cycles; on the last LOW cycle pulse_cnt increments, wrapping modulo 2^CNT_WIDTH.
REQ-019 SHALL, at the end of LOW, enter DONE if num_pulses != 0 and the incremented pulse_cnt equals num_pulses; otherwise it returns to HIGH.
REQ-020 SHALL keep DONE for one cycle with done=1 and busy=0, then enter IDLE.
REQ-021 SHALL hold busy=1 in HIGH and LOW only.
REQ-022 SHALL, when stop=1 in HIGH or LOW, go to IDLE on the next edge: pulse=0, done not asserted, pulse_cnt held.
REQ-023 SHALL ignore start outside IDLE, and shall ignore changes to half_period and num_pulses while busy.
REQ-024 SHALL let stop win when start=1 and stop=1 arrive together in IDLE, so no burst starts.
REQ-025 SHALL ignore stop in IDLE and DONE.
REQ-026 SHALL, with num_pulses=0, free-run until stop, with pulse_cnt wrapping and done never asserted.
REQ-027 SHALL hold pulse_cnt after a burst ends until the next accepted start.

Reset
REQ-028 SHALL, while rst=0, asynchronously force state=IDLE, pulse=0, busy=0, done=0, pulse_cnt=0, timer=0 and the latched fields to 0.
REQ-029 SHALL, when reset is asserted mid-burst, drop pulse immediately without asserting done.
REQ-030 SHALL accept start from the first clock edge after rst deasserts.

Structure
REQ-031 SHALL take its state encoding and the default CNT_WIDTH/DIV_WIDTH constants from the shared package pulse_gen_pkg.
REQ-032 SHALL place the phase timer in sub-module pulse_gen_timer, which loads H, counts down and flags the last cycle of a phase.
REQ-033 SHALL register every output, with no combinational path from any input to any output.

Verification
REQ-034 SHALL pass a bench where H=2, N=50, start at cycle 0 -> pulse period 4, 50 rising edges, done high only at cycle 201, pulse_cnt=50.
REQ-035 SHALL pass a bench where H=0, N=3 -> period 2 cycles, 3 pulses, done at cycle 7.
REQ-036 SHALL pass a bench where H=4, N=0, stop at cycle 100 -> pulse_cnt=12, pulse low from cycle 101, no done.
REQ-037 SHALL pass a bench where start is pulsed again at cycle 10 of an H=2, N=50 burst with H=5 -> ignored, period stays 4.
REQ-038 SHALL pass a bench where rst=0 at cycle 30 of a burst -> all outputs 0 at once; a later start restarts cleanly.
REQ-039 SHALL pass a bench where H=2, N=50 feeds freqcheck with en_count held for 200 cycles -> count reads 50.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared constants and FSM encoding for the burst pulse generator.
package pulse_gen_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int DIV_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_gen_timer.sv
// Phase timer: loads a phase length, counts down, flags the final cycle of the phase.
module pulse_gen_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A loaded value of 1 makes the very first cycle of the phase its last.
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_gen.sv
// Burst square-wave generator: N periods of 2*H cycles (N=0 free-runs), with abort and done strobe.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic [CNT_WIDTH-1:0] num_pulses,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulse_cnt,
  output logic [1:0]           state_dbg
);

  // start is a one-cycle request honoured only in IDLE; stop aborts HIGH/LOW on the
  // next edge and beats a simultaneous start; neither carries a ready/ack back.
  state_e               state_q;
  logic                 pulse_q, busy_q, done_q;
  logic [CNT_WIDTH-1:0] cnt_q, num_q, cnt_inc;
  logic [DIV_WIDTH-1:0] half_q, h_in_eff, h_lat_eff, load_val;
  logic                 in_burst, start_ok, timer_last, timer_load, timer_dec;

  assign h_in_eff  = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
  assign h_lat_eff = (half_q == '0) ? DIV_WIDTH'(1) : half_q;
  assign in_burst  = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign start_ok  = (state_q == ST_IDLE) && start && !stop;
  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    load_val   = h_lat_eff;
    if (start_ok) begin
      timer_load = 1'b1;
      load_val   = h_in_eff;
    end else if (in_burst && !stop) begin
      timer_load = timer_last;
      timer_dec  = !timer_last;
    end
  end

  pulse_gen_timer #(.W(DIV_WIDTH)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .val_i  (load_val),
    .last_o (timer_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
      half_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            half_q  <= half_period;
            num_q   <= num_pulses;
            cnt_q   <= '0;
            state_q <= ST_HIGH;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (stop) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (timer_last) begin
            state_q <= ST_LOW;
            pulse_q <= 1'b0;
          end
        end
        ST_LOW: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (timer_last) begin
            cnt_q <= cnt_inc;
            if ((num_q != '0) && (cnt_inc == num_q)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_HIGH;
              pulse_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: burst timing, free-run abort, ignored restart, mid-burst reset.
module tb_pulse_gen;

  localparam int CW = 16;
  localparam int DW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [DW-1:0] half_period = '0;
  logic [CW-1:0] num_pulses  = '0;
  logic          pulse, busy, done;
  logic [CW-1:0] pulse_cnt;
  logic [1:0]    state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;

  pulse_gen #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .num_pulses  (num_pulses),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .pulse_cnt   (pulse_cnt),
    .state_dbg   (state_dbg)
  );

  // frequency checker: counts rising edges of pulse while en_count is held
  logic en_count   = 1'b0;
  logic freq_clr   = 1'b0;
  logic prev_pulse = 1'b0;
  int   freq_count = 0;
  always @(negedge clk) begin
    prev_pulse <= pulse;
    if (freq_clr) freq_count <= 0;
    else if (en_count && pulse && !prev_pulse) freq_count <= freq_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start sampled on the next edge; the inputs are then scrambled to prove they were latched
  task automatic begin_burst(input int h, input int n);
    half_period = DW'(h);
    num_pulses  = CW'(n);
    start       = 1'b1;
    step();
    start       = 1'b0;
    half_period = DW'(h + 3);
    num_pulses  = CW'(n + 1);
  endtask

  // checks cycles 1..ncyc of a burst against the expected waveform
  task automatic check_burst(input string tag, input int h_eff, input int n, input int ncyc,
                             input int stop_at, input int inject_at, input int en_cycles);
    int period;
    int total;
    int ep, eb, ed, ec;
    period = 2 * h_eff;
    total  = n * period;
    for (int c = 1; c <= ncyc; c++) begin
      if (stop_at > 0 && c > stop_at) begin
        ep = 0; eb = 0; ed = 0; ec = ((stop_at - 1) / period) % 65536;
      end else if (n == 0 || c <= total) begin
        ep = (((c - 1) % period) < h_eff) ? 1 : 0;
        eb = 1; ed = 0; ec = ((c - 1) / period) % 65536;
      end else if (c == total + 1) begin
        ep = 0; eb = 0; ed = 1; ec = n;
      end else begin
        ep = 0; eb = 0; ed = 0; ec = n;
      end
      check($sformatf("%s pulse c%0d", tag, c), 32'(pulse), 32'(ep));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(eb));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(ed));
      check($sformatf("%s pulse_cnt c%0d", tag, c), 32'(pulse_cnt), 32'(ec));
      if (c == stop_at) stop = 1'b1;
      if (c == inject_at) begin
        start       = 1'b1;
        half_period = DW'(5);
        num_pulses  = CW'(7);
      end
      step();
      stop  = 1'b0;
      start = 1'b0;
      if (c == en_cycles) en_count = 1'b0;
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst pulse", 32'(pulse), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pulse_cnt", 32'(pulse_cnt), 32'd0);
    check("rst state", 32'(state_dbg), 32'd0);

    // H=2 N=50 from the first edge after reset release; freqcheck over 200 cycles
    rst      = 1'b1;
    freq_clr = 1'b1;
    begin_burst(2, 50);
    freq_clr = 1'b0;
    en_count = 1'b1;
    check_burst("h2n50", 2, 50, 203, 0, 0, 200);
    check("freqcheck count", 32'(freq_count), 32'd50);

    // H=0 behaves as H=1
    begin_burst(0, 3);
    check_burst("h0n3", 1, 3, 9, 0, 0, 0);

    // free-run, stopped at cycle 100
    begin_burst(4, 0);
    check_burst("h4free", 4, 0, 105, 100, 0, 0);

    // restart attempt at cycle 10 ignored; stop on the last LOW cycle holds the count
    begin_burst(2, 50);
    check_burst("restart", 2, 50, 45, 40, 10, 0);

    // start and stop together in IDLE: no burst
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop busy", 32'(busy), 32'd0);
    check("startstop pulse", 32'(pulse), 32'd0);
    check("startstop state", 32'(state_dbg), 32'd0);
    check("startstop cnt held", 32'(pulse_cnt), 32'd9);
    step();
    check("startstop busy2", 32'(busy), 32'd0);

    // reset at cycle 30 of a burst, then clean restart
    begin_burst(2, 50);
    check_burst("prereset", 2, 50, 29, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("midrst pulse", 32'(pulse), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst pulse_cnt", 32'(pulse_cnt), 32'd0);
    check("midrst state", 32'(state_dbg), 32'd0);
    #2;
    rst = 1'b1;
    step();
    begin_burst(1, 2);
    check_burst("postrst", 1, 2, 7, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
